// File: rtl/alu_operand_sequencer.sv
// Two-operand entry sequencer for a 6-bit signed display: a debounced button
// captures A, then B, then shows a registered ALU result with signed overflow.
module alu_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int WIDTH           = 6
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] switches,
  input  logic [2:0]       op_sel,
  input  logic             btn_enter,
  output logic [WIDTH-1:0] value,
  output logic             overflow,
  output logic [1:0]       phase,
  output logic             result_valid
);

  localparam int                CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A      = 2'b00,
    LOAD_B      = 2'b01,
    SHOW_RESULT = 2'b10,
    ILLEGAL     = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NEG = 3'b101,
    OP_SHL = 3'b110,
    OP_SAR = 3'b111
  } op_e;

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stable_q, stable_prev_q;
  logic [1:0]       warm_q;
  logic             armed_q;
  logic             press_q;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic             ovf_q, valid_q, live_q;

  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] alu_result_d;
  logic             alu_ovf_d;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample pre-edge values and the order of statements does not matter.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_enter;
      sync2_q <= sync1_q;
    end
  end

  // The stable level only moves after DEBOUNCE_CYCLES of continuous disagreement.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync2_q == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_q <= sync2_q;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A button still held through reset must be seen released (once the
  // synchronizer holds real samples) before any rising edge counts as a press.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      warm_q        <= 2'd0;
      armed_q       <= 1'b0;
      stable_prev_q <= 1'b0;
      press_q       <= 1'b0;
    end else begin
      if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
      if (warm_q == 2'd2 && !sync2_q) armed_q <= 1'b1;
      stable_prev_q <= stable_q;
      press_q       <= stable_q & ~stable_prev_q & armed_q;
    end
  end

  assign operand_b = (state_q == LOAD_B) ? switches : b_q;

  // NOTE: outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_result_d = '0;
    alu_ovf_d    = 1'b0;
    case (op_e'(op_sel))
      OP_ADD: begin
        alu_result_d = a_q + operand_b;
        alu_ovf_d    = (a_q[WIDTH-1] == operand_b[WIDTH-1]) &&
                       (alu_result_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result_d = a_q - operand_b;
        alu_ovf_d    = (a_q[WIDTH-1] != operand_b[WIDTH-1]) &&
                       (alu_result_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_result_d = a_q & operand_b;
      OP_OR:  alu_result_d = a_q | operand_b;
      OP_XOR: alu_result_d = a_q ^ operand_b;
      OP_NEG: begin
        alu_result_d = -a_q;
        alu_ovf_d    = (a_q == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_SHL: begin
        alu_result_d = {a_q[WIDTH-2:0], 1'b0};
        alu_ovf_d    = a_q[WIDTH-1] ^ a_q[WIDTH-2];
      end
      OP_SAR: alu_result_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        LOAD_A: if (press_q) begin
          a_q     <= switches;
          state_q <= LOAD_B;
        end
        LOAD_B: if (press_q) begin
          b_q      <= switches;
          result_q <= alu_result_d;
          ovf_q    <= alu_ovf_d;
          valid_q  <= 1'b1;
          state_q  <= SHOW_RESULT;
        end
        SHOW_RESULT: if (press_q) begin
          valid_q <= 1'b0;
          ovf_q   <= 1'b0;
          state_q <= LOAD_A;
        end
        default: begin
          valid_q <= 1'b0;
          ovf_q   <= 1'b0;
          state_q <= LOAD_A;
        end
      endcase
    end
  end

  // Switch pass-through is held at zero until the first clock after reset.
  always_comb begin
    value = '0;
    case (state_q)
      LOAD_A, LOAD_B: value = live_q ? switches : '0;
      SHOW_RESULT:    value = result_q;
      default:        value = '0;
    endcase
  end

  assign phase        = state_q;
  assign overflow     = ovf_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer: directed operand/opcode vectors,
// debounce timing, reset behaviour and held-button-through-reset handling.
module tb_alu_operand_sequencer;

  logic       clk_100MHz;
  logic       reset_n;
  logic [5:0] switches;
  logic [2:0] op_sel;
  logic       btn_enter;
  logic [5:0] value;
  logic       overflow;
  logic [1:0] phase;
  logic       result_valid;

  typedef struct packed {
    logic [5:0] value;
    logic       ovf;
  } exp_t;

  typedef struct packed {
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] op;
    logic [5:0] value;
    logic       ovf;
  } vec_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic valid_seen = 1'b0;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(4), .WIDTH(6)) dut (
    .clk_100MHz   (clk_100MHz),
    .reset_n      (reset_n),
    .switches     (switches),
    .op_sel       (op_sel),
    .btn_enter    (btn_enter),
    .value        (value),
    .overflow     (overflow),
    .phase        (phase),
    .result_valid (result_valid)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop one expected result each time the DUT starts presenting one.
  always @(negedge clk_100MHz) begin
    if (reset_n && result_valid && !valid_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: result value %0h with no expectation queued", value);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_value", 32'(value), 32'(e.value));
        check("sb_overflow", 32'(overflow), 32'(e.ovf));
      end
    end
    valid_seen = result_valid;
  end

  task automatic press();
    @(negedge clk_100MHz);
    btn_enter = 1'b1;
    repeat (12) @(negedge clk_100MHz);
    btn_enter = 1'b0;
    repeat (12) @(negedge clk_100MHz);
  endtask

  task automatic run_op(input vec_t v);
    exp_t e;
    switches = v.a;
    press();
    check("load_b_phase", 32'(phase), 32'(2'b01));
    switches = v.b;
    op_sel   = v.op;
    e.value  = v.value;
    e.ovf    = v.ovf;
    exp_q.push_back(e);
    press();
    check("show_phase", 32'(phase), 32'(2'b10));
    switches = 6'b010101;
    press();
    check("back_phase", 32'(phase), 32'(2'b00));
    check("back_valid", 32'(result_valid), 32'(1'b0));
    check("back_overflow", 32'(overflow), 32'(1'b0));
    check("back_passthru", 32'(value), 32'(6'b010101));
  endtask

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic advanced;

    //         A           B           op      expected    ovf
    vecs[0] = '{6'b100000, 6'b000001, 3'b001, 6'b011111, 1'b1}; // SUB -32-1 = 31
    vecs[1] = '{6'b000101, 6'b000111, 3'b001, 6'b111110, 1'b0}; // SUB 5-7 = -2
    vecs[2] = '{6'b100000, 6'b000000, 3'b101, 6'b100000, 1'b1}; // NEG -32
    vecs[3] = '{6'b111001, 6'b000000, 3'b111, 6'b111100, 1'b0}; // SAR -7 = -4
    vecs[4] = '{6'b010100, 6'b000000, 3'b110, 6'b101000, 1'b1}; // SHL 20 = -24
    vecs[5] = '{6'b010101, 6'b001100, 3'b010, 6'b000100, 1'b0}; // AND
    vecs[6] = '{6'b010101, 6'b001100, 3'b011, 6'b011101, 1'b0}; // OR
    vecs[7] = '{6'b010101, 6'b001100, 3'b100, 6'b011001, 1'b0}; // XOR
    vecs[8] = '{6'b100000, 6'b111111, 3'b000, 6'b011111, 1'b1}; // ADD -32+-1
    vecs[9] = '{6'b000011, 6'b000100, 3'b000, 6'b000111, 1'b0}; // ADD 3+4

    reset_n   = 1'b0;
    btn_enter = 1'b0;
    switches  = 6'b000011;
    op_sel    = 3'b000;
    repeat (3) @(negedge clk_100MHz);
    check("rst_value", 32'(value), 32'(6'd0));
    check("rst_phase", 32'(phase), 32'(2'b00));
    reset_n = 1'b1;
    @(negedge clk_100MHz);
    check("passthru_value", 32'(value), 32'(6'd3));
    check("passthru_phase", 32'(phase), 32'(2'b00));
    check("passthru_valid", 32'(result_valid), 32'(1'b0));

    // Short bounces must not advance.
    switches = 6'd25;
    for (int k = 0; k < 3; k++) begin
      btn_enter = 1'b1;
      repeat (2) @(negedge clk_100MHz);
      btn_enter = 1'b0;
      repeat (5) @(negedge clk_100MHz);
    end
    check("bounce_phase", 32'(phase), 32'(2'b00));

    // Held press: phase moves on the 8th rising edge after the raw assertion.
    btn_enter = 1'b1;
    n = 0;
    advanced = 1'b0;
    for (int i = 1; i <= 40 && !advanced; i++) begin
      @(posedge clk_100MHz);
      #1;
      if (phase != 2'b00) begin
        advanced = 1'b1;
        n = i;
      end
    end
    check("press_latency", 32'(n), 32'd8);
    repeat (12) @(negedge clk_100MHz);
    check("hold_one_advance", 32'(phase), 32'(2'b01));
    btn_enter = 1'b0;
    repeat (12) @(negedge clk_100MHz);
    check("release_no_advance", 32'(phase), 32'(2'b01));

    // ADD 25 + 10 wraps to -29 with overflow.
    switches = 6'd10;
    op_sel   = 3'b000;
    exp_q.push_back('{6'b100011, 1'b1});
    press();
    check("add_valid", 32'(result_valid), 32'(1'b1));
    switches = 6'b111111;
    op_sel   = 3'b111;
    repeat (3) @(negedge clk_100MHz);
    check("held_value", 32'(value), 32'(6'b100011));
    check("held_overflow", 32'(overflow), 32'(1'b1));

    // Mid-cycle reset clears outputs without waiting for a clock.
    @(posedge clk_100MHz);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_value", 32'(value), 32'(6'd0));
    check("async_phase", 32'(phase), 32'(2'b00));
    check("async_valid", 32'(result_valid), 32'(1'b0));
    check("async_overflow", 32'(overflow), 32'(1'b0));
    repeat (2) @(negedge clk_100MHz);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_100MHz);

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset during LOAD_B with the button held: no advance until a fresh press.
    switches = 6'd7;
    press();
    check("pre_rst_phase", 32'(phase), 32'(2'b01));
    btn_enter = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_100MHz);
    check("held_through_rst", 32'(phase), 32'(2'b00));
    btn_enter = 1'b0;
    repeat (12) @(negedge clk_100MHz);
    check("released_after_rst", 32'(phase), 32'(2'b00));
    press();
    check("fresh_press", 32'(phase), 32'(2'b01));

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
